// File: rtl/cgra_top.sv
// Four-sided CGRA top: each output side is a 16-bit processing element that picks
// an input side, applies one op with a per-side constant, and optionally registers it.
module cgra_top (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] config_addr_in,
    input  logic [31:0] config_data_in,
    input  logic pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in,
    input  logic pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
    input  logic pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in,
    input  logic pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
    input  logic pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in,
    input  logic pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
    input  logic pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in,
    input  logic pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
    input  logic pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in,
    input  logic pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
    input  logic pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in,
    input  logic pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
    input  logic pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in,
    input  logic pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
    input  logic pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in,
    input  logic pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
    output logic pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out,
    output logic pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
    output logic pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out,
    output logic pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
    output logic pad_S1_T0_out, pad_S1_T1_out, pad_S1_T2_out, pad_S1_T3_out,
    output logic pad_S1_T4_out, pad_S1_T5_out, pad_S1_T6_out, pad_S1_T7_out,
    output logic pad_S1_T8_out, pad_S1_T9_out, pad_S1_T10_out, pad_S1_T11_out,
    output logic pad_S1_T12_out, pad_S1_T13_out, pad_S1_T14_out, pad_S1_T15_out,
    output logic pad_S2_T0_out, pad_S2_T1_out, pad_S2_T2_out, pad_S2_T3_out,
    output logic pad_S2_T4_out, pad_S2_T5_out, pad_S2_T6_out, pad_S2_T7_out,
    output logic pad_S2_T8_out, pad_S2_T9_out, pad_S2_T10_out, pad_S2_T11_out,
    output logic pad_S2_T12_out, pad_S2_T13_out, pad_S2_T14_out, pad_S2_T15_out,
    output logic pad_S3_T0_out, pad_S3_T1_out, pad_S3_T2_out, pad_S3_T3_out,
    output logic pad_S3_T4_out, pad_S3_T5_out, pad_S3_T6_out, pad_S3_T7_out,
    output logic pad_S3_T8_out, pad_S3_T9_out, pad_S3_T10_out, pad_S3_T11_out,
    output logic pad_S3_T12_out, pad_S3_T13_out, pad_S3_T14_out, pad_S3_T15_out,
    input  logic        tdi,
    input  logic        tms,
    input  logic        tck,
    input  logic        trst_n,
    output logic        tdo
);

    logic [15:0] in_s   [4];
    logic [15:0] res_s  [4];
    logic [15:0] out_s  [4];
    logic [6:0]  cfg_q  [4];
    logic [6:0]  cfg_d  [4];
    logic [15:0] const_q[4];
    logic [15:0] const_d[4];
    logic [15:0] pipe_q [4];
    logic        unused_s;

    function automatic logic [15:0] pe_op(input logic [15:0] a, input logic [15:0] c,
                                          input logic [2:0] op);
        logic [15:0] r;
        case (op)
            3'd0:    r = a;
            3'd1:    r = a + c;
            3'd2:    r = a - c;
            3'd3:    r = a << c[3:0];
            3'd4:    r = a & c;
            3'd5:    r = a | c;
            3'd6:    r = a ^ c;
            3'd7:    r = a * c;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Track T0 is the MSB of each side word.
    assign in_s[0] = {pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in, pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
                      pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in, pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
    assign in_s[1] = {pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in, pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
                      pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in, pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
    assign in_s[2] = {pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in, pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
                      pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in, pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
    assign in_s[3] = {pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in, pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
                      pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in, pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

    // Config decode, PE result and output select per side.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            if (config_addr_in == (32'h0000_0010 + 32'(s))) begin
                cfg_d[s] = config_data_in[6:0];
            end else begin
                cfg_d[s] = cfg_q[s];
            end
            if (config_addr_in == (32'h0000_0020 + 32'(s))) begin
                const_d[s] = config_data_in[15:0];
            end else begin
                const_d[s] = const_q[s];
            end
            res_s[s] = pe_op(in_s[cfg_q[s][1:0]], const_q[s], cfg_q[s][4:2]);
            if (!cfg_q[s][6]) begin
                out_s[s] = 16'h0000;
            end else if (cfg_q[s][5]) begin
                out_s[s] = pipe_q[s];
            end else begin
                out_s[s] = res_s[s];
            end
        end
    end

    // Config and pipeline registers; all reads on an edge see pre-edge values.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int s = 0; s < 4; s++) begin
                cfg_q[s]   <= 7'h00;
                const_q[s] <= 16'h0000;
                pipe_q[s]  <= 16'h0000;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                cfg_q[s]   <= cfg_d[s];
                const_q[s] <= const_d[s];
                pipe_q[s]  <= res_s[s];
            end
        end
    end

    assign {pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out, pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
            pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out, pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = out_s[0];
    assign {pad_S1_T0_out, pad_S1_T1_out, pad_S1_T2_out, pad_S1_T3_out, pad_S1_T4_out, pad_S1_T5_out, pad_S1_T6_out, pad_S1_T7_out,
            pad_S1_T8_out, pad_S1_T9_out, pad_S1_T10_out, pad_S1_T11_out, pad_S1_T12_out, pad_S1_T13_out, pad_S1_T14_out, pad_S1_T15_out} = out_s[1];
    assign {pad_S2_T0_out, pad_S2_T1_out, pad_S2_T2_out, pad_S2_T3_out, pad_S2_T4_out, pad_S2_T5_out, pad_S2_T6_out, pad_S2_T7_out,
            pad_S2_T8_out, pad_S2_T9_out, pad_S2_T10_out, pad_S2_T11_out, pad_S2_T12_out, pad_S2_T13_out, pad_S2_T14_out, pad_S2_T15_out} = out_s[2];
    assign {pad_S3_T0_out, pad_S3_T1_out, pad_S3_T2_out, pad_S3_T3_out, pad_S3_T4_out, pad_S3_T5_out, pad_S3_T6_out, pad_S3_T7_out,
            pad_S3_T8_out, pad_S3_T9_out, pad_S3_T10_out, pad_S3_T11_out, pad_S3_T12_out, pad_S3_T13_out, pad_S3_T14_out, pad_S3_T15_out} = out_s[3];

    // JTAG exists only for pin compatibility.
    assign tdo      = 1'b0;
    assign unused_s = ^{tdi, tms, tck, trst_n, config_data_in[31:16]};

endmodule

// File: tb/tb_cgra_top.sv
// Scoreboard bench for cgra_top: expected side words are queued when stimulus is
// applied and popped when the corresponding outputs are sampled.
module tb_cgra_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data;
    logic [15:0] i0, i1, i2, i3;
    wire  [15:0] o0, o1, o2, o3;
    wire         tdo;
    logic        tdi = 1'b0, tms = 1'b0, tck = 1'b0, trst_n = 1'b1;

    typedef struct {
        int          side;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cgra_top dut (
        .clk_in(clk), .reset_in(rst), .config_addr_in(addr), .config_data_in(data),
        .pad_S0_T0_in(i0[15]), .pad_S0_T1_in(i0[14]), .pad_S0_T2_in(i0[13]), .pad_S0_T3_in(i0[12]),
        .pad_S0_T4_in(i0[11]), .pad_S0_T5_in(i0[10]), .pad_S0_T6_in(i0[9]), .pad_S0_T7_in(i0[8]),
        .pad_S0_T8_in(i0[7]), .pad_S0_T9_in(i0[6]), .pad_S0_T10_in(i0[5]), .pad_S0_T11_in(i0[4]),
        .pad_S0_T12_in(i0[3]), .pad_S0_T13_in(i0[2]), .pad_S0_T14_in(i0[1]), .pad_S0_T15_in(i0[0]),
        .pad_S1_T0_in(i1[15]), .pad_S1_T1_in(i1[14]), .pad_S1_T2_in(i1[13]), .pad_S1_T3_in(i1[12]),
        .pad_S1_T4_in(i1[11]), .pad_S1_T5_in(i1[10]), .pad_S1_T6_in(i1[9]), .pad_S1_T7_in(i1[8]),
        .pad_S1_T8_in(i1[7]), .pad_S1_T9_in(i1[6]), .pad_S1_T10_in(i1[5]), .pad_S1_T11_in(i1[4]),
        .pad_S1_T12_in(i1[3]), .pad_S1_T13_in(i1[2]), .pad_S1_T14_in(i1[1]), .pad_S1_T15_in(i1[0]),
        .pad_S2_T0_in(i2[15]), .pad_S2_T1_in(i2[14]), .pad_S2_T2_in(i2[13]), .pad_S2_T3_in(i2[12]),
        .pad_S2_T4_in(i2[11]), .pad_S2_T5_in(i2[10]), .pad_S2_T6_in(i2[9]), .pad_S2_T7_in(i2[8]),
        .pad_S2_T8_in(i2[7]), .pad_S2_T9_in(i2[6]), .pad_S2_T10_in(i2[5]), .pad_S2_T11_in(i2[4]),
        .pad_S2_T12_in(i2[3]), .pad_S2_T13_in(i2[2]), .pad_S2_T14_in(i2[1]), .pad_S2_T15_in(i2[0]),
        .pad_S3_T0_in(i3[15]), .pad_S3_T1_in(i3[14]), .pad_S3_T2_in(i3[13]), .pad_S3_T3_in(i3[12]),
        .pad_S3_T4_in(i3[11]), .pad_S3_T5_in(i3[10]), .pad_S3_T6_in(i3[9]), .pad_S3_T7_in(i3[8]),
        .pad_S3_T8_in(i3[7]), .pad_S3_T9_in(i3[6]), .pad_S3_T10_in(i3[5]), .pad_S3_T11_in(i3[4]),
        .pad_S3_T12_in(i3[3]), .pad_S3_T13_in(i3[2]), .pad_S3_T14_in(i3[1]), .pad_S3_T15_in(i3[0]),
        .pad_S0_T0_out(o0[15]), .pad_S0_T1_out(o0[14]), .pad_S0_T2_out(o0[13]), .pad_S0_T3_out(o0[12]),
        .pad_S0_T4_out(o0[11]), .pad_S0_T5_out(o0[10]), .pad_S0_T6_out(o0[9]), .pad_S0_T7_out(o0[8]),
        .pad_S0_T8_out(o0[7]), .pad_S0_T9_out(o0[6]), .pad_S0_T10_out(o0[5]), .pad_S0_T11_out(o0[4]),
        .pad_S0_T12_out(o0[3]), .pad_S0_T13_out(o0[2]), .pad_S0_T14_out(o0[1]), .pad_S0_T15_out(o0[0]),
        .pad_S1_T0_out(o1[15]), .pad_S1_T1_out(o1[14]), .pad_S1_T2_out(o1[13]), .pad_S1_T3_out(o1[12]),
        .pad_S1_T4_out(o1[11]), .pad_S1_T5_out(o1[10]), .pad_S1_T6_out(o1[9]), .pad_S1_T7_out(o1[8]),
        .pad_S1_T8_out(o1[7]), .pad_S1_T9_out(o1[6]), .pad_S1_T10_out(o1[5]), .pad_S1_T11_out(o1[4]),
        .pad_S1_T12_out(o1[3]), .pad_S1_T13_out(o1[2]), .pad_S1_T14_out(o1[1]), .pad_S1_T15_out(o1[0]),
        .pad_S2_T0_out(o2[15]), .pad_S2_T1_out(o2[14]), .pad_S2_T2_out(o2[13]), .pad_S2_T3_out(o2[12]),
        .pad_S2_T4_out(o2[11]), .pad_S2_T5_out(o2[10]), .pad_S2_T6_out(o2[9]), .pad_S2_T7_out(o2[8]),
        .pad_S2_T8_out(o2[7]), .pad_S2_T9_out(o2[6]), .pad_S2_T10_out(o2[5]), .pad_S2_T11_out(o2[4]),
        .pad_S2_T12_out(o2[3]), .pad_S2_T13_out(o2[2]), .pad_S2_T14_out(o2[1]), .pad_S2_T15_out(o2[0]),
        .pad_S3_T0_out(o3[15]), .pad_S3_T1_out(o3[14]), .pad_S3_T2_out(o3[13]), .pad_S3_T3_out(o3[12]),
        .pad_S3_T4_out(o3[11]), .pad_S3_T5_out(o3[10]), .pad_S3_T6_out(o3[9]), .pad_S3_T7_out(o3[8]),
        .pad_S3_T8_out(o3[7]), .pad_S3_T9_out(o3[6]), .pad_S3_T10_out(o3[5]), .pad_S3_T11_out(o3[4]),
        .pad_S3_T12_out(o3[3]), .pad_S3_T13_out(o3[2]), .pad_S3_T14_out(o3[1]), .pad_S3_T15_out(o3[0]),
        .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
    );

    function automatic logic [15:0] get_out(input int s);
        case (s)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return o3;
        endcase
    endfunction

    // Present one config word for one rising edge, sample 1 time unit later.
    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        data = d;
        @(posedge clk);
        #1;
        addr = 32'h0;
        data = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = 32'h0; data = 32'h0;
        i0 = 16'($urandom); i1 = 16'($urandom); i2 = 16'($urandom); i3 = 16'($urandom);
        #1;
        for (int s = 0; s < 4; s++) sb.push_back('{s, 16'h0000, "reset_during"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (get_out(e.side) !== e.val) begin
                n_fail++;
                $display("FAIL %s side%0d: got %h expected %h", e.name, e.side, get_out(e.side), e.val);
            end
        end
        n_tests++;
        if (tdo !== 1'b0) begin
            n_fail++;
            $display("FAIL tdo_reset: got %b expected 0", tdo);
        end
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) sb.push_back('{s, 16'h0000, "reset_after"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (get_out(e.side) !== e.val) begin
                n_fail++;
                $display("FAIL %s side%0d: got %h expected %h", e.name, e.side, get_out(e.side), e.val);
            end
        end
    endtask

    task automatic test_write_in_reset();
        i2 = 16'h0003;
        rst = 1'b1;
        addr = 32'h10; data = 32'h4E;
        @(posedge clk);
        #1;
        rst = 1'b0;
        addr = 32'h0; data = 32'h0;
        @(posedge clk);
        #1;
        sb.push_back('{0, 16'h0000, "write_in_reset_lost"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
    endtask

    task automatic test_mul_pow2();
        int bad;
        i2 = 16'h0003;
        cfg_write(32'h20, 32'h1);
        cfg_write(32'h10, 32'h4E);
        sb.push_back('{0, 16'h0006, "mul_pow2"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
        n_tests++;
        if ({dut.pad_S0_T13_out, dut.pad_S0_T14_out, dut.pad_S0_T15_out, dut.pad_S0_T0_out} !== 4'b1100) begin
            n_fail++;
            $display("FAIL mul_pads: T13 T14 T15 T0 got %b expected 1100",
                     {dut.pad_S0_T13_out, dut.pad_S0_T14_out, dut.pad_S0_T15_out, dut.pad_S0_T0_out});
        end
        sb.push_back('{0, 16'h0006, "mul_stable"});
        e = sb.pop_front();
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (get_out(e.side) !== e.val) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d unstable cycles, last got %h expected %h", e.name, bad, get_out(e.side), e.val);
        end
        i2 = 16'h0007;
        #1;
        sb.push_back('{0, 16'h000E, "comb_zero_latency"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
        i2 = 16'h0003;
    endtask

    task automatic test_registered();
        cfg_write(32'h10, 32'h6E);
        sb.push_back('{0, 16'h0006, "reg_initial"});
        i2 = 16'h0005;
        #1;
        sb.push_back('{0, 16'h0006, "reg_before_edge"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (get_out(e.side) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
            end
        end
        @(posedge clk);
        #1;
        sb.push_back('{0, 16'h000A, "reg_after_edge"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
    endtask

    task automatic test_wrap();
        i3 = 16'hFFFF;
        cfg_write(32'h21, 32'h1);
        cfg_write(32'h11, 32'h47);
        sb.push_back('{1, 16'h0000, "add_wrap"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
        i3 = 16'h0000;
        cfg_write(32'h11, 32'h4B);
        sb.push_back('{1, 16'hFFFF, "sub_wrap"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
    endtask

    task automatic test_ignored();
        cfg_write(32'h00, 32'hFFFF_FFFF);
        cfg_write(32'h14, 32'hFFFF_FFFF);
        cfg_write(32'h30, 32'hFFFF_FFFF);
        sb.push_back('{0, 16'h000A, "ignored_s0"});
        sb.push_back('{1, 16'hFFFF, "ignored_s1"});
        sb.push_back('{2, 16'h0000, "ignored_s2"});
        sb.push_back('{3, 16'h0000, "ignored_s3"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (get_out(e.side) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
            end
        end
        cfg_write(32'h10, 32'h2E);
        sb.push_back('{0, 16'h0000, "en_clear"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
    endtask

    // Side 3 reads side 0 through every op; upper data bits are set to show they are ignored.
    task automatic test_ops();
        logic [15:0] a, c, r;
        for (int op = 0; op < 8; op++) begin
            a = 16'($urandom);
            c = (op == 3) ? 16'hFFFF : 16'($urandom);
            case (op)
                0:       r = a;
                1:       r = a + c;
                2:       r = a - c;
                3:       r = a << c[3:0];
                4:       r = a & c;
                5:       r = a | c;
                6:       r = a ^ c;
                default: r = a * c;
            endcase
            i0 = a;
            cfg_write(32'h23, {16'hA5C3, c});
            cfg_write(32'h13, 32'hFFFF_FF80 | 32'h40 | (32'(op) << 2));
            sb.push_back('{3, r, $sformatf("op%0d", op)});
            e = sb.pop_front();
            n_tests++;
            if (get_out(e.side) !== e.val) begin
                n_fail++;
                $display("FAIL %s a=%h c=%h: got %h expected %h", e.name, a, c, get_out(e.side), e.val);
            end
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        i2 = 16'h0003;
        cfg_write(32'h10, 32'h6E);
        sb.push_back('{0, 16'h0006, "pre_reset_reg"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
        #2;
        rst = 1'b1;
        #1;
        sb.push_back('{0, 16'h0000, "mid_reset_immediate"});
        e = sb.pop_front();
        n_tests++;
        if (get_out(e.side) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, get_out(e.side), e.val);
        end
        #1;
        rst = 1'b0;
        for (int s = 0; s < 4; s++) sb.push_back('{s, 16'h0000, "post_reset_hold"});
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) if (get_out(s) !== 16'h0000) bad++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (get_out(e.side) !== e.val || bad != 0) begin
                n_fail++;
                $display("FAIL %s side%0d: got %h expected %h (%0d nonzero samples)", e.name, e.side, get_out(e.side), e.val, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_in_reset();
        test_mul_pow2();
        test_registered();
        test_wrap();
        test_ignored();
        test_ops();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
